// File: rtl/median_pkg.sv
// Shared definitions for the median line buffer and the median filter stage it feeds.
package median_pkg;

  localparam int unsigned DEFAULT_WIDTH    = 32;
  localparam int unsigned DEFAULT_LINE_LEN = 64;
  localparam int unsigned DEFAULT_NUM_ROWS = 64;

  // FILL: rows 0 and 1 are still loading the line memories; STREAM: rows 2 and up
  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage : median_pkg

// File: rtl/line_ram.sv
// Single-port line memory: combinational read, registered write, so a read and
// write to the same address in one cycle returns the old contents.
module line_ram #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; the FILL phase covers stale data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule : line_ram

// File: rtl/median_line_buffer.sv
// Two-line buffer that turns a raster pixel stream into vertical column triples
// (rows r-2, r-1, r) for a 3-row median filter.
module median_line_buffer
  import median_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned LINE_LEN = DEFAULT_LINE_LEN,
  parameter int unsigned NUM_ROWS = DEFAULT_NUM_ROWS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word0,
  output logic [WIDTH-1:0] out_word1,
  output logic [WIDTH-1:0] out_word2,
  output logic             frame_done
);

  localparam int unsigned COL_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             accept;
  logic             last_col;
  logic             last_row;
  logic [WIDTH-1:0] a_rd;
  logic [WIDTH-1:0] b_rd;

  // Single output register: accept whenever it is empty or being drained.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign last_col = (col == COL_W'(LINE_LEN - 1));
  assign last_row = (row == ROW_W'(NUM_ROWS - 1));

  // A holds row r-1, B holds row r-2; B takes A's old word as A takes the new pixel.
  line_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (LINE_LEN),
    .ADDR_W (COL_W)
  ) u_line_a (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (in_data),
    .rdata (a_rd)
  );

  line_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (LINE_LEN),
    .ADDR_W (COL_W)
  ) u_line_b (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (a_rd),
    .rdata (b_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_word0  <= '0;
      out_word1  <= '0;
      out_word2  <= '0;
    end else begin
      frame_done <= accept && last_col && last_row;

      if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end

        case (state)
          FILL:    if (last_col && row == ROW_W'(1)) state <= STREAM;
          STREAM:  if (last_col && last_row)         state <= FILL;
          default: state <= FILL;
        endcase
      end

      // Reload on a qualifying accept, otherwise drain when consumed; a stall
      // blocks accept, so the register holds by construction.
      if (accept && state == STREAM) begin
        out_valid <= 1'b1;
        out_word0 <= b_rd;
        out_word1 <= a_rd;
        out_word2 <= in_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule : median_line_buffer

// File: tb/tb_median_line_buffer.sv
// Directed bench for median_line_buffer with LINE_LEN=4, NUM_ROWS=4, pixel data = index.
module tb_median_line_buffer;

  localparam int unsigned W  = 32;
  localparam int unsigned LL = 4;
  localparam int unsigned NR = 4;

  typedef logic [3*W-1:0] trip_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_word0;
  logic [W-1:0] out_word1;
  logic [W-1:0] out_word2;
  logic         frame_done;

  int    n_cmp  = 0;
  int    n_fail = 0;
  int    cyc    = 0;
  trip_t trip_q[$];
  trip_t fd_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  median_line_buffer #(
    .WIDTH    (W),
    .LINE_LEN (LL),
    .NUM_ROWS (NR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word0  (out_word0),
    .out_word1  (out_word1),
    .out_word2  (out_word2),
    .frame_done (frame_done)
  );

  // Record consumed triples and the triple present on each frame_done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) trip_q.push_back({out_word0, out_word1, out_word2});
      if (frame_done) fd_q.push_back({out_word0, out_word1, out_word2});
    end
  end

  function automatic trip_t mk(input int unsigned a);
    return {W'(a), W'(a + 4), W'(a + 8)};
  endfunction

  task automatic send_pixel(input int unsigned d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = W'(d);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_pixel_timeout: pixel %0d not accepted, required accept within 100 cycles", d);
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    n_cmp++; if ({out_word0, out_word1, out_word2} !== trip_t'(0)) begin n_fail++; $display("FAIL reset_words: got %h want 0", {out_word0, out_word1, out_word2}); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_stream();
    trip_q.delete(); fd_q.delete(); out_ready = 1'b1;
    for (int p = 0; p < 16; p++) begin
      send_pixel(p);
      if (p == 7) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_fill_suppress: out_valid %b want 0", out_valid); end
      end
      if (p == 8) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_latency: out_valid %b want 1", out_valid); end
        n_cmp++; if ({out_word0, out_word1, out_word2} !== mk(0)) begin n_fail++; $display("FAIL stream_first: got %h want %h", {out_word0, out_word1, out_word2}, mk(0)); end
      end
      if (p == 15) begin
        n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL stream_frame_done_pulse: got %b want 1", frame_done); end
      end
    end
    drain();
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL stream_frame_done_width: got %b want 0", frame_done); end
    n_cmp++; if (trip_q.size() != 8) begin n_fail++; $display("FAIL stream_count: got %0d want 8", trip_q.size()); end
    for (int i = 0; i < 8 && i < trip_q.size(); i++) begin
      n_cmp++; if (trip_q[i] !== mk(i)) begin n_fail++; $display("FAIL stream_triple[%0d]: got %h want %h", i, trip_q[i], mk(i)); end
    end
    n_cmp++; if (fd_q.size() != 1) begin n_fail++; $display("FAIL stream_fd_count: got %0d want 1", fd_q.size()); end
    if (fd_q.size() > 0) begin
      n_cmp++; if (fd_q[0] !== mk(7)) begin n_fail++; $display("FAIL stream_fd_triple: got %h want %h", fd_q[0], mk(7)); end
    end
  endtask

  task automatic test_backpressure();
    trip_q.delete(); fd_q.delete(); out_ready = 1'b1;
    for (int p = 0; p < 9; p++) send_pixel(p);
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(9);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %b want 1", out_valid); end
    n_cmp++; if ({out_word0, out_word1, out_word2} !== mk(0)) begin n_fail++; $display("FAIL bp_hold_words: got %h want %h", {out_word0, out_word1, out_word2}, mk(0)); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    for (int p = 9; p < 16; p++) send_pixel(p);
    drain();
    n_cmp++; if (trip_q.size() != 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", trip_q.size()); end
    for (int i = 0; i < 8 && i < trip_q.size(); i++) begin
      n_cmp++; if (trip_q[i] !== mk(i)) begin n_fail++; $display("FAIL bp_triple[%0d]: got %h want %h", i, trip_q[i], mk(i)); end
    end
  endtask

  task automatic test_back_to_back();
    int start;
    trip_q.delete(); fd_q.delete(); out_ready = 1'b1;
    start = cyc;
    for (int p = 0; p < 32; p++) send_pixel(p);
    n_cmp++; if (cyc - start != 32) begin n_fail++; $display("FAIL b2b_cycles: got %0d want 32", cyc - start); end
    drain();
    n_cmp++; if (trip_q.size() != 16) begin n_fail++; $display("FAIL b2b_count: got %0d want 16", trip_q.size()); end
    for (int i = 0; i < 16 && i < trip_q.size(); i++) begin
      n_cmp++; if (trip_q[i] !== mk(i < 8 ? i : i + 8)) begin n_fail++; $display("FAIL b2b_triple[%0d]: got %h want %h", i, trip_q[i], mk(i < 8 ? i : i + 8)); end
    end
    n_cmp++; if (fd_q.size() != 2) begin n_fail++; $display("FAIL b2b_fd_count: got %0d want 2", fd_q.size()); end
    if (fd_q.size() > 1) begin
      n_cmp++; if (fd_q[0] !== mk(7)) begin n_fail++; $display("FAIL b2b_fd0: got %h want %h", fd_q[0], mk(7)); end
      n_cmp++; if (fd_q[1] !== mk(23)) begin n_fail++; $display("FAIL b2b_fd1: got %h want %h", fd_q[1], mk(23)); end
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    for (int p = 0; p < 6; p++) send_pixel(p);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL mrst_frame_done: got %b want 0", frame_done); end
    n_cmp++; if ({out_word0, out_word1, out_word2} !== trip_t'(0)) begin n_fail++; $display("FAIL mrst_words: got %h want 0", {out_word0, out_word1, out_word2}); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_in_ready: got %b want 1", in_ready); end
    trip_q.delete(); fd_q.delete();
    for (int p = 0; p < 16; p++) send_pixel(100 + p);
    drain();
    n_cmp++; if (trip_q.size() != 8) begin n_fail++; $display("FAIL mrst_count: got %0d want 8", trip_q.size()); end
    for (int i = 0; i < 8 && i < trip_q.size(); i++) begin
      n_cmp++; if (trip_q[i] !== mk(100 + i)) begin n_fail++; $display("FAIL mrst_triple[%0d]: got %h want %h", i, trip_q[i], mk(100 + i)); end
    end
    n_cmp++; if (fd_q.size() != 1) begin n_fail++; $display("FAIL mrst_fd_count: got %0d want 1", fd_q.size()); end
  endtask

  task automatic test_random();
    int idx = 0;
    bit acc;
    trip_q.delete(); fd_q.delete(); in_valid = 1'b0;
    for (int c = 0; c < 3000 && idx < 48; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_data  = W'(idx % 16);
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        in_valid = 1'b0;
      end
    end
    n_cmp++; if (idx != 48) begin n_fail++; $display("FAIL rand_progress: got %0d pixels want 48", idx); end
    drain();
    n_cmp++; if (trip_q.size() != 24) begin n_fail++; $display("FAIL rand_count: got %0d want 24", trip_q.size()); end
    for (int i = 0; i < 24 && i < trip_q.size(); i++) begin
      n_cmp++; if (trip_q[i] !== mk(i % 8)) begin n_fail++; $display("FAIL rand_triple[%0d]: got %h want %h", i, trip_q[i], mk(i % 8)); end
    end
    n_cmp++; if (fd_q.size() != 3) begin n_fail++; $display("FAIL rand_fd_count: got %0d want 3", fd_q.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 50000 cycles");
    $fatal(1);
  end

endmodule : tb_median_line_buffer

// File: doc/median_line_buffer.md
MEDIAN_LINE_BUFFER -- requirements
Module: median_line_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, pixel word width.
REQ-002 SHALL have parameter LINE_LEN, default 64, pixels per image line (legal range 2..4096).
REQ-003 SHALL have parameter NUM_ROWS, default 64, lines per frame (legal range 3..4096).
REQ-004 SHALL have port clk  in  1  clock; all state updates on posedge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  in  1  upstream pixel valid.
REQ-007 SHALL have port in_ready  out  1  pixel accepted this cycle when in_valid && in_ready.
REQ-008 SHALL have port in_data  in  WIDTH  raster-order pixel.
REQ-009 SHALL have port out_valid  out  1  column triple valid.
REQ-010 SHALL have port out_ready  in  1  downstream (median filter) accepts triple.
REQ-011 SHALL have ports out_word0, out_word1, out_word2  out  WIDTH each  same column from rows r-2, r-1, r; these drive the median filter's word0/word1/word2 inputs.
REQ-012 SHALL have port frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-013 SHALL hold two line memories A (row r-1) and B (row r-2), LINE_LEN x WIDTH each, addressed by column counter col.
REQ-014 SHALL drive in_ready = !out_valid || out_ready (one output register stage, no bubble under continuous flow).
REQ-015 On accept, SHALL write B[col] <= A[col], A[col] <= in_data, and load out_word2 <= in_data, out_word1 <= A[col], out_word0 <= B[col].
REQ-016 SHALL set out_valid on the cycle after an accept only if the accepted pixel's row >= 2; latency input-accept to output-valid is exactly 1 cycle.
REQ-017 SHALL clear out_valid when out_valid && out_ready and no new qualifying accept occurs in the same cycle; simultaneous consume and accept reloads the register and keeps out_valid high.
REQ-018 SHALL hold out_word0..2 and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL implement states FILL (row < 2) and STREAM (row >= 2): FILL->STREAM on accept of pixel (row 1, col LINE_LEN-1); STREAM->FILL on accept of pixel (NUM_ROWS-1, LINE_LEN-1).
REQ-020 SHALL increment col on every accept, wrapping LINE_LEN-1 -> 0 and then incrementing row; row wraps NUM_ROWS-1 -> 0.
REQ-021 SHALL pulse frame_done for exactly one cycle, the cycle after the last pixel of a frame is accepted, coincident with that pixel's output triple going valid.
REQ-022 SHALL emit exactly (NUM_ROWS-2)*LINE_LEN triples per frame; frames stream back-to-back with no idle cycle required.
REQ-023 SHALL NOT require line memory initialisation; stale contents are never presented because FILL suppresses out_valid.
REQ-024 Counters col and row SHALL be sized $clog2 of their limits; no arithmetic on pixel data.

Reset
REQ-025 On rst, SHALL set out_valid=0, frame_done=0, col=0, row=0, state=FILL; out_word0..2 reset to 0.
REQ-026 rst mid-frame SHALL discard the partial frame; the next accepted pixel is treated as row 0, col 0; in_ready is 1 the cycle after rst deasserts.
REQ-027 Line memories SHALL NOT be reset.

Structure
REQ-028 Shared package median_pkg SHALL hold WIDTH default, state enum (FILL, STREAM) and default LINE_LEN/NUM_ROWS constants, shared with the median filter stage.
REQ-029 One sub-module line_ram (single-port, same-address read-before-write, registered write, combinational read) SHALL be instantiated twice for A and B.

Verification (LINE_LEN=4, NUM_ROWS=4, in_data = pixel index)
REQ-030 Stream pixels 0..15, out_ready=1 -> first triple (0,4,8) one cycle after pixel 8 accepted; last triple (7,11,15); 8 triples total; frame_done once with (7,11,15).
REQ-031 Hold out_ready=0 after pixel 8 -> out_valid stays 1 with (0,4,8), in_ready=0, pixel 9 not consumed; release -> (1,5,9) follows in order.
REQ-032 Second frame 16..31 back-to-back -> first triple (16,20,24), no triples from frame seam, second frame_done at (23,27,31).
REQ-033 Assert rst for 1 cycle after pixel 5 accepted, then send 100..115 -> first triple (100,104,108), outputs/flags zero during reset.
REQ-034 Random in_valid/out_ready toggling over 3 frames -> triple sequence identical to REQ-030 reference, none dropped or duplicated.
